mod_updown_counter: RTL and testbench

Parametrised successor to the team's basic 4-bit up counter. It is a modulo-N up/down counter with synchronous parallel load, count enable, an enable prescaler, and wrap or saturate boundary modes. It also raises a one-cycle boundary event pulse and a sticky overflow flag. It is intended as the generic timing/sequence counter for datapath and test-bench timing blocks.

---
 rtl/mod_updown_counter.sv | 101 ++++++++++
 tb/tb_mod_updown_counter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// ============================================================================
// Module  : mod_updown_counter
// Brief   : Modulo-N up/down counter with load, enable prescaler, wrap/saturate
//           boundary modes, boundary event pulse and sticky overflow flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 15,
  parameter int PRESCALE = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Sat,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             ClrOvf,
  output logic [WIDTH-1:0] Count,
  output logic             Evt,
  output logic             Ovf,
  output logic             AtMax,
  output logic             AtMin
);

  localparam int              PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
  localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);

  generate
    if (WIDTH < 1 || MAX_VAL < 1 || MAX_VAL > (2 ** WIDTH) - 1 || PRESCALE < 1) begin : g_param_check
      $error("mod_updown_counter: illegal parameter combination");
    end
  endgenerate

  logic [PW-1:0]    psc;
  logic [PW-1:0]    psc_next;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] load_clamped;
  logic             step;
  logic             boundary;

  assign AtMax = (Count == MAX_C);
  assign AtMin = (Count == '0);

  always_comb begin
    step         = En && (psc == PS_LAST);
    boundary     = 1'b0;
    count_next   = Count;
    psc_next     = psc;
    load_clamped = (LoadVal > MAX_C) ? MAX_C : LoadVal;

    if (En) begin
      psc_next = step ? '0 : psc + 1'b1;
    end

    if (step) begin
      if (Up) begin
        if (AtMax) begin
          boundary   = 1'b1;
          count_next = Sat ? MAX_C : '0;
        end else begin
          count_next = Count + 1'b1;
        end
      end else begin
        if (AtMin) begin
          boundary   = 1'b1;
          count_next = Sat ? '0 : MAX_C;
        end else begin
          count_next = Count - 1'b1;
        end
      end
    end
  end

  // Load leaves Ovf alone apart from an explicit ClrOvf; a boundary set beats ClrOvf.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Count <= '0;
      psc   <= '0;
      Evt   <= 1'b0;
      Ovf   <= 1'b0;
    end else if (Load) begin
      Count <= load_clamped;
      psc   <= '0;
      Evt   <= 1'b0;
      Ovf   <= Ovf & ~ClrOvf;
    end else begin
      Count <= count_next;
      psc   <= psc_next;
      Evt   <= boundary;
      Ovf   <= boundary | (Ovf & ~ClrOvf);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: two instances (PRESCALE=1 and PRESCALE=3, MAX_VAL=9)
// checked against a reference model through per-instance expectation queues.
`default_nettype none

module tb_mod_updown_counter;

  localparam int MAXV = 9;

  typedef struct packed {
    logic [3:0] cnt;
    logic       evt;
    logic       ovf;
    logic       amax;
    logic       amin;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0, en = 1'b0, up = 1'b0, sat = 1'b0, load = 1'b0, clr_ovf = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] cnt0, cnt1;
  logic       evt0, evt1, ovf0, ovf1, amax0, amax1, amin0, amin1;
  obs_t       o0, o1, e0, e1;

  obs_t q0[$];
  obs_t q1[$];
  int   m_cnt[2];
  int   m_psc[2];
  bit   m_evt[2];
  bit   m_ovf[2];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(MAXV), .PRESCALE(1)) u_p1 (
    .Clk(clk), .Reset(reset), .En(en), .Up(up), .Sat(sat), .Load(load),
    .LoadVal(load_val), .ClrOvf(clr_ovf), .Count(cnt0), .Evt(evt0), .Ovf(ovf0),
    .AtMax(amax0), .AtMin(amin0)
  );

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(MAXV), .PRESCALE(3)) u_p3 (
    .Clk(clk), .Reset(reset), .En(en), .Up(up), .Sat(sat), .Load(load),
    .LoadVal(load_val), .ClrOvf(clr_ovf), .Count(cnt1), .Evt(evt1), .Ovf(ovf1),
    .AtMax(amax1), .AtMin(amin1)
  );

  assign o0 = {cnt0, evt0, ovf0, amax0, amin0};
  assign o1 = {cnt1, evt1, ovf1, amax1, amin1};

  // Reference behaviour for instance d, evaluated on the inputs present before the edge.
  task automatic model_step(input int d);
    int   ps;
    bit   ev;
    obs_t e;
    ps = (d == 0) ? 1 : 3;
    ev = 1'b0;
    if (reset) begin
      m_cnt[d] = 0; m_psc[d] = 0; m_evt[d] = 1'b0; m_ovf[d] = 1'b0;
    end else if (load) begin
      m_cnt[d] = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
      m_psc[d] = 0;
      m_evt[d] = 1'b0;
      if (clr_ovf) m_ovf[d] = 1'b0;
    end else begin
      if (en) begin
        if (m_psc[d] == ps - 1) begin
          m_psc[d] = 0;
          if (up) begin
            if (m_cnt[d] == MAXV) begin ev = 1'b1; m_cnt[d] = sat ? MAXV : 0; end
            else m_cnt[d] = (m_cnt[d] + 1) % (MAXV + 1);
          end else begin
            if (m_cnt[d] == 0) begin ev = 1'b1; m_cnt[d] = sat ? 0 : MAXV; end
            else m_cnt[d] = m_cnt[d] - 1;
          end
        end else begin
          m_psc[d] = m_psc[d] + 1;
        end
      end
      m_evt[d] = ev;
      if (ev) m_ovf[d] = 1'b1;
      else if (clr_ovf) m_ovf[d] = 1'b0;
    end
    e.cnt  = 4'(m_cnt[d]);
    e.evt  = m_evt[d];
    e.ovf  = m_ovf[d];
    e.amax = (m_cnt[d] == MAXV);
    e.amin = (m_cnt[d] == 0);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Push expectations, take one edge, and settle to the sample point.
  task automatic drive_cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    e0 = q0.pop_front();
    e1 = q1.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; up = 1'b0; sat = 1'b0; load = 1'b0; clr_ovf = 1'b0; load_val = '0;
    for (int i = 0; i < 2; i++) begin
      drive_cycle();
      tests += 2;
      if (o0 !== e0) begin fails++; $display("FAIL reset p1 cyc %0d: got %h want %h", i, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL reset p3 cyc %0d: got %h want %h", i, o1, e1); end
    end
    tests++;
    if ({cnt0, amin0, amax0, evt0, ovf0} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset_state: got cnt=%0d amin=%b amax=%b evt=%b ovf=%b want 0 1 0 0 0",
                        cnt0, amin0, amax0, evt0, ovf0);
    end
    reset = 1'b0;
  endtask

  task automatic test_wrap_up();
    en = 1'b1; up = 1'b1; sat = 1'b0;
    for (int i = 0; i < 11; i++) begin
      drive_cycle();
      tests += 3;
      if (o0 !== e0) begin fails++; $display("FAIL wrap_up p1 cyc %0d: got %h want %h", i, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL wrap_up p3 cyc %0d: got %h want %h", i, o1, e1); end
      if ({cnt0, evt0, amax0} !== {4'((i + 1) % 10), (i == 9), (i == 8)}) begin
        fails++; $display("FAIL wrap_up_seq cyc %0d: got cnt=%0d evt=%b amax=%b want %0d %b %b",
                          i, cnt0, evt0, amax0, (i + 1) % 10, (i == 9), (i == 8));
      end
    end
    tests++;
    if (ovf0 !== 1'b1) begin fails++; $display("FAIL wrap_up_ovf: got %b want 1", ovf0); end
  endtask

  task automatic test_wrap_down();
    reset = 1'b1; en = 1'b0;
    drive_cycle();
    tests += 2;
    if (o0 !== e0) begin fails++; $display("FAIL down_rst p1: got %h want %h", o0, e0); end
    if (o1 !== e1) begin fails++; $display("FAIL down_rst p3: got %h want %h", o1, e1); end
    reset = 1'b0; en = 1'b1; up = 1'b0; sat = 1'b0;
    for (int i = 0; i < 11; i++) begin
      clr_ovf = (i == 4) || (i == 10);
      drive_cycle();
      tests += 2;
      if (o0 !== e0) begin fails++; $display("FAIL wrap_down p1 cyc %0d: got %h want %h", i, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL wrap_down p3 cyc %0d: got %h want %h", i, o1, e1); end
      if (i == 0) begin
        tests++;
        if ({cnt0, evt0, ovf0} !== {4'd9, 1'b1, 1'b1}) begin
          fails++; $display("FAIL down_first_wrap: got cnt=%0d evt=%b ovf=%b want 9 1 1", cnt0, evt0, ovf0);
        end
      end
      if (i == 4) begin
        tests++;
        if ({cnt0, ovf0} !== {4'd5, 1'b0}) begin
          fails++; $display("FAIL clr_ovf: got cnt=%0d ovf=%b want 5 0", cnt0, ovf0);
        end
      end
    end
    tests++;
    if ({cnt0, evt0, ovf0} !== {4'd9, 1'b1, 1'b1}) begin
      fails++; $display("FAIL clr_vs_wrap: got cnt=%0d evt=%b ovf=%b want 9 1 1", cnt0, evt0, ovf0);
    end
    clr_ovf = 1'b0;
  endtask

  task automatic test_saturate();
    int exp_c[5] = '{8, 9, 9, 9, 9};
    bit exp_e[5] = '{0, 0, 1, 1, 1};
    sat = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd7; en = 1'b0; clr_ovf = 1'b1;
    drive_cycle();
    tests += 2;
    if (o0 !== e0) begin fails++; $display("FAIL sat_load p1: got %h want %h", o0, e0); end
    if (o1 !== e1) begin fails++; $display("FAIL sat_load p3: got %h want %h", o1, e1); end
    load = 1'b0; clr_ovf = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_cycle();
      tests += 3;
      if (o0 !== e0) begin fails++; $display("FAIL sat_up p1 cyc %0d: got %h want %h", i, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL sat_up p3 cyc %0d: got %h want %h", i, o1, e1); end
      if ({cnt0, evt0, ovf0} !== {4'(exp_c[i]), exp_e[i], exp_e[i]}) begin
        fails++; $display("FAIL sat_up_seq cyc %0d: got cnt=%0d evt=%b ovf=%b want %0d %b %b",
                          i, cnt0, evt0, ovf0, exp_c[i], exp_e[i], exp_e[i]);
      end
    end
    up = 1'b0; load = 1'b1; load_val = 4'd1;
    for (int i = 0; i < 4; i++) begin
      drive_cycle();
      load = 1'b0;
      tests += 2;
      if (o0 !== e0) begin fails++; $display("FAIL sat_down p1 cyc %0d: got %h want %h", i, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL sat_down p3 cyc %0d: got %h want %h", i, o1, e1); end
    end
  endtask

  task automatic test_load();
    int exp_p3[3] = '{9, 9, 8};
    sat = 1'b0; up = 1'b1; en = 1'b0; load = 1'b1; load_val = 4'd2;
    for (int i = 0; i < 2; i++) begin
      drive_cycle();
      load = 1'b0; en = 1'b1;
      tests += 2;
      if (o0 !== e0) begin fails++; $display("FAIL load_pre p1 cyc %0d: got %h want %h", i, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL load_pre p3 cyc %0d: got %h want %h", i, o1, e1); end
    end
    load = 1'b1; load_val = 4'd12; en = 1'b1;
    drive_cycle();
    tests += 3;
    if (o0 !== e0) begin fails++; $display("FAIL load_clamp p1: got %h want %h", o0, e0); end
    if (o1 !== e1) begin fails++; $display("FAIL load_clamp p3: got %h want %h", o1, e1); end
    if ({cnt0, amax0, cnt1, amax1} !== {4'd9, 1'b1, 4'd9, 1'b1}) begin
      fails++; $display("FAIL load_clamp_val: got %0d/%b %0d/%b want 9/1 9/1", cnt0, amax0, cnt1, amax1);
    end
    load = 1'b0; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle();
      tests += 3;
      if (o0 !== e0) begin fails++; $display("FAIL load_psc p1 cyc %0d: got %h want %h", i, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL load_psc p3 cyc %0d: got %h want %h", i, o1, e1); end
      if (cnt1 !== 4'(exp_p3[i])) begin
        fails++; $display("FAIL load_psc_zero cyc %0d: got %0d want %0d", i, cnt1, exp_p3[i]);
      end
    end
  endtask

  task automatic test_prescale();
    reset = 1'b1;
    drive_cycle();
    reset = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      int want;
      en = !(k >= 8 && k <= 11);
      drive_cycle();
      want = (k <= 7) ? k / 3 : (k <= 11) ? 2 : (k == 12) ? 2 : 3;
      tests += 3;
      if (o0 !== e0) begin fails++; $display("FAIL prescale p1 edge %0d: got %h want %h", k, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL prescale p3 edge %0d: got %h want %h", k, o1, e1); end
      if (cnt1 !== 4'(want)) begin
        fails++; $display("FAIL prescale_phase edge %0d: got %0d want %0d", k, cnt1, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; en = 1'b0;
    drive_cycle();
    reset = 1'b0; load = 1'b1; load_val = 4'd9; up = 1'b1; sat = 1'b1;
    drive_cycle();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) begin up = 1'b0; sat = 1'b0; end
      drive_cycle();
      tests += 2;
      if (o0 !== e0) begin fails++; $display("FAIL mid_pre p1 cyc %0d: got %h want %h", i, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL mid_pre p3 cyc %0d: got %h want %h", i, o1, e1); end
    end
    tests++;
    if ({cnt1, ovf1} !== {4'd6, 1'b1}) begin
      fails++; $display("FAIL mid_setup: got cnt=%0d ovf=%b want 6 1", cnt1, ovf1);
    end
    reset = 1'b1;
    drive_cycle();
    tests++;
    if ({cnt1, ovf1, evt1, cnt0, ovf0, evt0} !== {4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL mid_reset: got p3 %0d/%b/%b p1 %0d/%b/%b want all zero",
                        cnt1, ovf1, evt1, cnt0, ovf0, evt0);
    end
    reset = 1'b0; up = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive_cycle();
      tests += 3;
      if (o0 !== e0) begin fails++; $display("FAIL mid_post p1 cyc %0d: got %h want %h", i, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL mid_post p3 cyc %0d: got %h want %h", i, o1, e1); end
      if (cnt1 !== 4'(i / 3)) begin
        fails++; $display("FAIL mid_restart cyc %0d: got %0d want %0d", i, cnt1, i / 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      reset    = ($urandom_range(0, 39) == 0);
      load     = ($urandom_range(0, 7) == 0);
      clr_ovf  = ($urandom_range(0, 7) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up       = ($urandom_range(0, 3) != 0);
      sat      = ($urandom_range(0, 3) == 0);
      load_val = 4'($urandom_range(0, 15));
      drive_cycle();
      tests += 2;
      if (o0 !== e0) begin fails++; $display("FAIL random p1 cyc %0d: got %h want %h", i, o0, e0); end
      if (o1 !== e1) begin fails++; $display("FAIL random p3 cyc %0d: got %h want %h", i, o1, e1); end
    end
    reset = 1'b0; load = 1'b0; clr_ovf = 1'b0; en = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load();
    test_prescale();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
